// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: parity modes, TX/RX state encodings, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    // RX_BREAK parks the receiver after a framing error until the line idles high.
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // Clock cycles per oversampling tick, rounded to the nearest integer.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        longint den;
        den = longint'(baud) * longint'(os);
        return int'((longint'(clk_freq) + den / 2) / den);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Oversampling tick generator: one-cycle tick every DIV clocks.
// Latency: first tick DIV cycles after reset or restart.
// Backpressure: none; free-running, restart realigns the phase.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // Divider counter; restart pulls the phase to the detected start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 cnt <= '0;
        else if (restart || tick) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_core.sv
`timescale 1ns/1ps
// UART transceiver: independent TX and oversampled majority-vote RX with error flags.
// Latency: tx low one cycle after accept; rx_valid one cycle after first stop-bit vote.
// Backpressure: tx_ready gates tx_start; RX never stalls, un-acked frames raise rx_overrun.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);
    localparam int DIV = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
    localparam int CPB = DIV * OVERSAMPLE;
    localparam int TCW = $clog2(STOP_BITS * CPB);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int SW  = $clog2(OVERSAMPLE);

    // ---------------- transmitter ----------------
    tx_state_t            tx_state, tx_state_n;
    logic [TCW-1:0]       tx_cnt;
    logic [BW-1:0]        tx_idx;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par, tx_line_n, tx_bit_done, tx_stop_done;

    assign tx_bit_done  = (tx_cnt == TCW'(CPB - 1));
    assign tx_stop_done = (tx_cnt == TCW'(STOP_BITS * CPB - 1));
    assign tx_ready     = (tx_state == TX_IDLE);

    // TX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_state_n;
    end

    // TX next state, plus the line level the next state will drive (tx is registered).
    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_start) tx_state_n = TX_START;
            TX_START:  if (tx_bit_done) tx_state_n = TX_DATA;
            TX_DATA:   if (tx_bit_done && tx_idx == BW'(DATA_BITS - 1))
                           tx_state_n = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
            TX_PARITY: if (tx_bit_done) tx_state_n = TX_STOP;
            TX_STOP:   if (tx_stop_done) tx_state_n = TX_IDLE;
            default:   tx_state_n = TX_IDLE;
        endcase
        tx_line_n = 1'b1;
        case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            // The shift happens on the same edge, so look one bit ahead at a bit boundary.
            TX_DATA:   tx_line_n = (tx_state == TX_DATA && tx_bit_done) ? tx_shreg[1] : tx_shreg[0];
            TX_PARITY: tx_line_n = tx_par;
            default:   tx_line_n = 1'b1;
        endcase
    end

    // TX datapath: bit timer, payload shifter, parity and registered line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx <= tx_line_n;
            if (tx_state == TX_IDLE || tx_state_n != tx_state || (tx_state == TX_DATA && tx_bit_done))
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 1'b1;
            if (tx_state == TX_IDLE && tx_start) begin
                tx_shreg <= tx_data;
                tx_idx   <= '0;
                tx_par   <= (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;
            end else if (tx_state == TX_DATA && tx_bit_done) begin
                tx_shreg <= tx_shreg >> 1;
                tx_idx   <= tx_idx + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t            rx_state, rx_state_n;
    logic                 rx_meta, rx_s, rx_prev, rx_fall, restart, tick;
    logic [SW-1:0]        tick_cnt;
    logic [1:0]           samp;
    logic                 sample_now, decide, bit_end, maj, report, pending, rx_par;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_shreg;

    assign rx_fall    = rx_prev & ~rx_s;
    assign restart    = (rx_state == RX_IDLE) && rx_fall;
    assign sample_now = tick && (tick_cnt == SW'(OVERSAMPLE/2 - 1) || tick_cnt == SW'(OVERSAMPLE/2));
    assign decide     = tick && (tick_cnt == SW'(OVERSAMPLE/2 + 1));
    assign bit_end    = tick && (tick_cnt == SW'(OVERSAMPLE - 1));
    assign maj        = maj3(samp[1], samp[0], rx_s);
    assign report     = (rx_state == RX_STOP) && decide;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Tick position within the current bit, and the first two of the three vote samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            samp     <= 2'b11;
        end else begin
            if (restart)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= (tick_cnt == SW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + 1'b1;
            if (sample_now)
                samp <= {samp[0], rx_s};
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_state_n;
    end

    // RX next state: bit advance on the last tick, start/stop decisions on the vote tick.
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_fall) rx_state_n = RX_START;
            RX_START:  if (decide && maj) rx_state_n = RX_IDLE;
                       else if (bit_end) rx_state_n = RX_DATA;
            RX_DATA:   if (bit_end && rx_idx == BW'(DATA_BITS - 1))
                           rx_state_n = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
            RX_PARITY: if (bit_end) rx_state_n = RX_STOP;
            RX_STOP:   if (decide) rx_state_n = maj ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (rx_s) rx_state_n = RX_IDLE;
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    // RX datapath: payload/parity capture, frame report, pending/overrun bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_idx        <= '0;
            rx_shreg      <= '0;
            rx_par        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
            pending       <= 1'b0;
        end else begin
            rx_valid <= report;
            if (rx_state == RX_START)
                rx_idx <= '0;
            else if (rx_state == RX_DATA && bit_end)
                rx_idx <= rx_idx + 1'b1;
            if (rx_state == RX_DATA && decide)
                rx_shreg <= {maj, rx_shreg[DATA_BITS-1:1]};
            if (rx_state == RX_PARITY && decide)
                rx_par <= maj;
            if (report) begin
                rx_data       <= rx_shreg;
                rx_frame_err  <= ~maj;
                rx_parity_err <= (PARITY != PAR_NONE) && ((^rx_shreg ^ rx_par) != (PARITY == PAR_ODD));
                pending       <= 1'b1;
                // An ack landing on the report cycle retires the previous frame first.
                rx_overrun    <= (rx_overrun | pending) & ~rx_ack;
            end else if (rx_ack) begin
                pending    <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
// Directed bench for uart_core: default-config instance plus an even-parity instance.
// Latency: bit time 432 cycles at 50 MHz / 115200 baud.
// Backpressure: exercised through tx_ready, rx_ack and rx_overrun.
module tb_uart_core;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data_p;
    logic       tx_start, tx_start_p, tx_ready, tx_ready_p, tx, tx_p;
    logic       rx_line, rx_line_p, rx_ack, rx_ack_p;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, rx_valid_p, rx_frame_err, rx_frame_err_p;
    logic       rx_parity_err, rx_parity_err_p, rx_overrun, rx_overrun_p;

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;
    int vcnt_p   = 0;

    uart_core u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
        .tx(tx), .rx(rx_line), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
    );

    uart_core #(.PARITY(2)) u_par (
        .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_start(tx_start_p), .tx_ready(tx_ready_p),
        .tx(tx_p), .rx(rx_line_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ack(rx_ack_p),
        .rx_frame_err(rx_frame_err_p), .rx_parity_err(rx_parity_err_p), .rx_overrun(rx_overrun_p)
    );

    always #10 clk = ~clk;

    // Count rx_valid cycles; a correct one-cycle pulse adds exactly one per frame.
    always @(negedge clk) begin
        if (rx_valid)   vcnt++;
        if (rx_valid_p) vcnt_p++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame on an RX line: start, 8 data LSB first, optional parity, one stop.
    task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                        input logic par, input logic stop, input int cyc);
        logic [10:0] bits;
        int n;
        n    = has_par ? 11 : 10;
        bits = has_par ? {stop, par, d, 1'b0} : {1'b1, stop, d, 1'b0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel) rx_line_p = bits[i]; else rx_line = bits[i];
            repeat (cyc - 1) @(negedge clk);
        end
        @(negedge clk);
        if (sel) rx_line_p = 1'b1; else rx_line = 1'b1;
        repeat (300) @(negedge clk);
    endtask

    task automatic ack(input bit sel);
        @(negedge clk);
        if (sel) rx_ack_p = 1'b1; else rx_ack = 1'b1;
        @(negedge clk);
        rx_ack   = 1'b0;
        rx_ack_p = 1'b0;
    endtask

    // Called at a negedge with the transmitter idle; returns at the negedge after acceptance.
    task automatic start_tx(input bit sel, input logic [7:0] d);
        if (sel) begin tx_data_p = d; tx_start_p = 1'b1; end
        else     begin tx_data   = d; tx_start   = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        tx_start   = 1'b0;
        tx_start_p = 1'b0;
    endtask

    // Cycle k (k=0: first cycle after acceptance) belongs to bit k/432; check each bit's
    // first, middle and last cycle, the total busy time and the return of tx_ready.
    task automatic tx_watch(input bit sel, input logic [10:0] bits, input int nbits, input string tag);
        int busy;
        int total;
        logic line, rdy;
        busy  = 0;
        total = nbits * 432;
        for (int k = 0; k < total + 80; k++) begin
            if (k > 0) @(negedge clk);
            line = sel ? tx_p : tx;
            rdy  = sel ? tx_ready_p : tx_ready;
            if (!rdy) busy++;
            if (k < total && (k % 432 == 0 || k % 432 == 216 || k % 432 == 431))
                check($sformatf("%s_bit%0d_at%0d", tag, k / 432, k % 432), {31'b0, line}, {31'b0, bits[k / 432]});
            if (k == total)
                check({tag, "_ready_back"}, {31'b0, rdy}, 32'd1);
        end
        check({tag, "_busy_cycles"}, busy, total);
    endtask

    initial begin
        rst = 1'b0;
        tx_data = 8'h00; tx_data_p = 8'h00; tx_start = 1'b0; tx_start_p = 1'b0;
        rx_line = 1'b1; rx_line_p = 1'b1; rx_ack = 1'b0; rx_ack_p = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_tx",        {31'b0, tx},            32'd1);
        check("rst_tx_ready",  {31'b0, tx_ready},      32'd1);
        check("rst_rx_data",   {24'b0, rx_data},       32'd0);
        check("rst_rx_valid",  {31'b0, rx_valid},      32'd0);
        check("rst_frame_err", {31'b0, rx_frame_err},  32'd0);
        check("rst_par_err",   {31'b0, rx_parity_err}, 32'd0);
        check("rst_overrun",   {31'b0, rx_overrun},    32'd0);
        check("rst_tx_p",      {31'b0, tx_p},          32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // TX 0x55 while RX concurrently receives 0xA3 at +3% bit time; a start
        // request during the busy period must be ignored and must not corrupt the frame.
        fork
            begin
                start_tx(0, 8'h55);
                tx_watch(0, {1'b1, 1'b1, 8'h55, 1'b0}, 10, "tx55");
            end
            send(0, 8'hA3, 0, 1'b0, 1'b1, 445);
            begin
                repeat (1000) @(negedge clk);
                tx_data = 8'hFF; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        check("a3_valid_cnt", vcnt,                    32'd1);
        check("a3_data",      {24'b0, rx_data},        32'hA3);
        check("a3_frame_err", {31'b0, rx_frame_err},   32'd0);
        check("a3_par_err",   {31'b0, rx_parity_err},  32'd0);
        check("a3_overrun",   {31'b0, rx_overrun},     32'd0);
        check("tx_after_idle", {31'b0, tx},            32'd1);
        ack(0);

        // -3% bit time
        send(0, 8'h5C, 0, 1'b0, 1'b1, 419);
        check("5c_valid_cnt", vcnt,             32'd2);
        check("5c_data",      {24'b0, rx_data}, 32'h5C);
        ack(0);

        // Even parity instance: TX 0x07 (parity bit 1) alongside RX 0x07 with wrong parity 0
        fork
            begin
                start_tx(1, 8'h07);
                tx_watch(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, "txp07");
            end
            send(1, 8'h07, 1, 1'b0, 1'b1, 432);
        join
        check("p07bad_valid_cnt", vcnt_p,                  32'd1);
        check("p07bad_data",      {24'b0, rx_data_p},      32'h07);
        check("p07bad_par_err",   {31'b0, rx_parity_err_p}, 32'd1);
        check("p07bad_frame_err", {31'b0, rx_frame_err_p},  32'd0);
        ack(1);
        send(1, 8'h07, 1, 1'b1, 1'b1, 432);
        check("p07ok_valid_cnt", vcnt_p,                  32'd2);
        check("p07ok_par_err",   {31'b0, rx_parity_err_p}, 32'd0);
        check("p07ok_overrun",   {31'b0, rx_overrun_p},    32'd0);

        // Framing error then recovery
        send(0, 8'h3C, 0, 1'b0, 1'b0, 432);
        check("3c_valid_cnt", vcnt,                  32'd3);
        check("3c_data",      {24'b0, rx_data},      32'h3C);
        check("3c_frame_err", {31'b0, rx_frame_err}, 32'd1);
        ack(0);
        send(0, 8'h11, 0, 1'b0, 1'b1, 432);
        check("11_valid_cnt", vcnt,                   32'd4);
        check("11_data",      {24'b0, rx_data},       32'h11);
        check("11_frame_err", {31'b0, rx_frame_err},  32'd0);
        check("11_par_err",   {31'b0, rx_parity_err}, 32'd0);
        ack(0);

        // Overrun: two frames without ack, then ack clears it
        send(0, 8'h01, 0, 1'b0, 1'b1, 432);
        check("01_data",     {24'b0, rx_data},    32'h01);
        check("01_overrun",  {31'b0, rx_overrun}, 32'd0);
        send(0, 8'h02, 0, 1'b0, 1'b1, 432);
        check("02_valid_cnt", vcnt,               32'd6);
        check("02_data",     {24'b0, rx_data},    32'h02);
        check("02_overrun",  {31'b0, rx_overrun}, 32'd1);
        ack(0);
        @(negedge clk);
        check("ack_overrun", {31'b0, rx_overrun}, 32'd0);
        check("ack_data",    {24'b0, rx_data},    32'h02);

        // 2 us low glitch must not produce a frame
        @(negedge clk);
        rx_line = 1'b0;
        repeat (100) @(negedge clk);
        rx_line = 1'b1;
        repeat (600) @(negedge clk);
        check("glitch_valid_cnt", vcnt, 32'd6);

        // Asynchronous reset in the middle of sending 0xFF (during the start bit)
        start_tx(0, 8'hFF);
        repeat (200) @(negedge clk);
        check("pre_rst_tx",       {31'b0, tx},       32'd0);
        check("pre_rst_tx_ready", {31'b0, tx_ready}, 32'd0);
        #5;
        rst = 1'b0;
        #1;
        check("async_rst_tx",       {31'b0, tx},       32'd1);
        check("async_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("async_rst_rx_data",  {24'b0, rx_data},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_tx",       {31'b0, tx},       32'd1);
        check("post_rst_tx_ready", {31'b0, tx_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Synthesizable, parametrised UART transceiver: one transmitter and one receiver sharing a clock.
- Configurable data width, parity mode and stop-bit count.
- Receiver uses oversampling with 3-sample majority vote.
- Reports framing, parity and overrun errors.
- Sits between board RS232 pins (after the level shifter) and on-chip logic; replaces ad-hoc per-project serial logic.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUDRATE, 115_200: line bit rate.
- OVERSAMPLE, 16: RX samples per bit; must be ≥ 8 and even.
- DATA_BITS, 8: payload bits per frame, 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: reset. One clock; reset is asynchronous and active-low.
- tx_data, in, DATA_BITS: byte to send, LSB first.
- tx_start, in, 1: send request; accepted only when tx_ready = 1.
- tx_ready, out, 1: transmitter idle, can accept.
- tx, out, 1: serial output, idle high.
- rx, in, 1: serial input, asynchronous.
- rx_data, out, DATA_BITS: last received payload.
- rx_valid, out, 1: one-cycle pulse, rx_data and error flags valid.
- rx_ack, in, 1: consumer has taken rx_data; clears pending.
- rx_frame_err, out, 1: stop bit sampled low in the frame just reported.
- rx_parity_err, out, 1: parity mismatch in the frame just reported.
- rx_overrun, out, 1: sticky; a new frame completed while the previous one was un-acked. Cleared by rx_ack.

Behaviour:
Reset values: tx = 1, tx_ready = 1, rx_data = 0, rx_valid = 0, all error flags = 0. Both FSMs go to IDLE immediately, including mid-frame.

Constants:
- DIV = round(CLK_FREQ / (BAUDRATE × OVERSAMPLE)).
- CLKS_PER_BIT = DIV × OVERSAMPLE.

TX FSM (IDLE → START → DATA → PARITY → STOP → IDLE):
- tx_start && tx_ready at edge N: tx_data latched; tx_ready = 0 and tx = 0 from N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles, counted by the TX's own counter restarted at acceptance.
- DATA sends DATA_BITS bits, LSB first.
- PARITY is skipped when PARITY = 0. Odd mode: the parity bit makes the count of ones (data + parity) odd. Even mode: makes it even.
- STOP holds tx = 1 for STOP_BITS × CLKS_PER_BIT cycles; tx_ready = 1 on the cycle after STOP ends.
- tx_start while busy is ignored; no queuing.

RX path:
- rx passes through a 2-FF synchroniser, flops reset to 1.
- A free-running tick from the sub-module pulses every DIV cycles.
- RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE: a synchronised high→low transition enters START and resets the tick count.
- Each bit's value is the majority of samples at ticks OVERSAMPLE/2−1, /2 and /2+1 within that bit.
- START: majority 1 means a false start; return to IDLE with no report.
- DATA / PARITY: majority samples per bit, as above.
- STOP: only the first stop bit is checked. Majority 0 sets rx_frame_err for this frame.
- At the end of the first stop-bit sample:
  - rx_valid pulses for 1 cycle.
  - rx_data is updated.
  - rx_frame_err and rx_parity_err are updated; they hold until the next rx_valid.
  - If the previous frame is still pending (no rx_ack since the last rx_valid), rx_overrun is set and rx_data is overwritten.
- rx_ack in the same cycle as rx_valid acknowledges the new frame.
- After a framing error, the FSM waits for the line to be high before re-arming IDLE (no break re-trigger).
- TX and RX are fully independent; simultaneous operation is required.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE / PAR_ODD / PAR_EVEN;
  - TX/RX state encodings;
  - a function computing DIV from CLK_FREQ, BAUDRATE and OVERSAMPLE.
- One sub-module, uart_baud_tick: parametrised divider producing a 1-cycle tick every DIV cycles, with a synchronous restart input used by RX start detection.

Test Plan (defaults: DIV = 27, CLKS_PER_BIT = 432, bit time 8640 ns):
- tx_start with tx_data = 0x55 → tx shows 0,1,0,1,0,1,0,1,0,1 with each bit 432 cycles; tx_ready = 0 for 4320 cycles, then 1.
- Line drives 0xA3 at 115200 with ±3% bit-time skew → one rx_valid, rx_data = 0xA3, no errors.
- PARITY = 2, line frame 0x07 with parity bit 0 → rx_parity_err = 1, rx_data = 0x07. Same frame with parity 1 → no error.
- Frame 0x3C with stop bit forced low → rx_frame_err = 1. A following correct frame 0x11 → flags clear, rx_data = 0x11.
- Two frames 0x01 then 0x02 with no rx_ack → rx_overrun = 1, rx_data = 0x02. rx_ack → rx_overrun = 0.
- 2 µs low glitch on rx → no rx_valid. rst low mid-TX of 0xFF → tx = 1 and tx_ready = 1 asynchronously.
